constrained_lfsr_random: RTL

CONSTRAINED_LFSR_RANDOM -- requirements
Module: constrained_lfsr_random

---
 rtl/constrained_lfsr_random_if.sv | 38 +++
 rtl/constrained_lfsr_random.sv | 126 ++++++++++++
 2 files changed

// File: rtl/constrained_lfsr_random_if.sv
`default_nettype none
// ============================================================================
//  Module   : constrained_lfsr_random_if
//  Brief    : Consumer-side bundle for the constrained LFSR random source:
//             take strobe, runtime seed load, value/valid and reject count.
//  Revision : 1.0  initial release
// ============================================================================
interface constrained_lfsr_random_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic             seed_ld;
  logic [63:0]      seed;
  logic [WIDTH-1:0] out;
  logic             valid;
  logic [15:0]      rejects;

  // Consumer side: drives strobes and seed, observes generated values.
  modport master (
    output en,
    output seed_ld,
    output seed,
    input  out,
    input  valid,
    input  rejects
  );

  // Generator side.
  modport slave (
    input  en,
    input  seed_ld,
    input  seed,
    output out,
    output valid,
    output rejects
  );
endinterface
`default_nettype wire

// File: rtl/constrained_lfsr_random.sv
`default_nettype none
// ============================================================================
//  Module   : constrained_lfsr_random
//  Brief    : 64-bit Galois LFSR feeding a rejection sampler that produces
//             registered values uniformly within [MIN, MAX], with a one-deep
//             valid/take output stage and a saturating reject counter.
//  Revision : 1.0  initial release
// ============================================================================
module constrained_lfsr_random #(
  parameter int unsigned WIDTH = 8,
  parameter logic [63:0] MIN   = 64'd0,
  parameter logic [63:0] MAX   = 64'd255,
  parameter logic [63:0] SEED  = 64'h0000_0000_0000_0001
) (
  input  wire                              clk,
  input  wire                              rst_n,
  constrained_lfsr_random_if.slave         bus
);

  localparam logic [63:0] C_POLY      = 64'hD800_0000_0000_0000;
  localparam logic [63:0] C_ZERO_SEED = 64'hACE1_ACE1_ACE1_ACE1;

  // Smallest all-ones mask that covers span values (span held at 65 bits so
  // that a full 64-bit range does not overflow).
  function automatic logic [63:0] calc_mask(input logic [64:0] span);
    logic [64:0] m;
    m = 65'd0;
    for (int i = 0; i < 65; i++) begin
      if ((m + 65'd1) < span) m = {m[63:0], 1'b1};
    end
    return m[63:0];
  endfunction

  function automatic logic [63:0] lfsr_next(input logic [63:0] l);
    return {1'b0, l[63:1]} ^ (l[0] ? C_POLY : 64'h0);
  endfunction

  localparam logic [64:0]      C_SPAN    = {1'b0, MAX} - {1'b0, MIN} + 65'd1;
  localparam logic [63:0]      C_RANGE   = MAX - MIN;
  localparam logic [63:0]      C_MASK    = calc_mask(C_SPAN);
  localparam logic [63:0]      C_RESET_L = (SEED == 64'd0) ? C_ZERO_SEED : SEED;
  localparam logic [WIDTH-1:0] C_OUT_RST = MIN[WIDTH-1:0];

  typedef enum logic [0:0] {
    ST_GEN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [63:0]      l_q, l_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [15:0]      rejects_q, rejects_d;

  logic [63:0]      l_next;
  logic [63:0]      cand;
  logic             accept;
  logic [15:0]      rejects_inc;

  // Candidate derived from the advanced LFSR; the mask never exceeds WIDTH
  // bits because the span is legal for the output width.
  always_comb begin
    l_next      = lfsr_next(l_q);
    cand        = l_next & C_MASK;
    accept      = (cand <= C_RANGE);
    rejects_inc = (rejects_q == 16'hFFFF) ? rejects_q : rejects_q + 16'd1;
  end

  // Next-state logic: seed load overrides everything; GEN always draws;
  // HOLD draws only when the consumer takes the current value.
  always_comb begin
    state_d   = state_q;
    l_d       = l_q;
    out_d     = out_q;
    rejects_d = rejects_q;
    if (bus.seed_ld) begin
      l_d       = (bus.seed == 64'd0) ? C_ZERO_SEED : bus.seed;
      rejects_d = 16'd0;
      state_d   = ST_GEN;
    end else begin
      case (state_q)
        ST_GEN: begin
          l_d = l_next;
          if (accept) begin
            out_d   = WIDTH'(MIN + cand);
            state_d = ST_HOLD;
          end else begin
            rejects_d = rejects_inc;
          end
        end
        ST_HOLD: begin
          if (bus.en) begin
            l_d = l_next;
            if (accept) begin
              out_d = WIDTH'(MIN + cand);
            end else begin
              rejects_d = rejects_inc;
              state_d   = ST_GEN;
            end
          end
        end
        default: state_d = ST_GEN;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_GEN;
      l_q       <= C_RESET_L;
      out_q     <= C_OUT_RST;
      rejects_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      l_q       <= l_d;
      out_q     <= out_d;
      rejects_q <= rejects_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.valid   = (state_q == ST_HOLD);
  assign bus.rejects = rejects_q;

endmodule
`default_nettype wire
